fetch_sequencer: RTL and testbench

Controller that sequences the byte-wide instruction memory of the MIPS fetch stage. It assembles each 32-bit big-endian instruction from four single-byte reads, holds it under a valid/ready handshake toward decode, and advances the PC by 4 or redirects it on branch/jump. It also shares the memory port with a program loader, which has priority.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/fetch_sequencer.sv | 121 ++++++++++++
 tb/tb_fetch_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared constants and types for the MIPS fetch stage
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int          ADDR_W      = 7;
  localparam logic [31:0] RESET_PC    = 32'd0;
  localparam int          INSTR_BYTES = 4;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer : byte-serial instruction fetch with loader port sharing
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter int          ADDR_W   = mips_pkg::ADDR_W,
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_gnt,
  input  logic              redir_valid,
  input  logic [31:0]       redir_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic [31:0]       pc_plus4
);

  import mips_pkg::*;

  localparam logic [1:0] LAST_IDX = 2'(INSTR_BYTES - 1);

  state_e      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;

  logic [4:0]  ins_shift;
  logic [31:0] ins_mask;
  logic [31:0] ins_byte;
  logic        unused_redir_lsbs;

  assign unused_redir_lsbs = ^redir_pc[1:0];

  // Loader owns the port whenever it asks; gating with rst_n keeps the grant low during reset.
  assign ld_gnt    = ld_req & rst_n;
  assign mem_we    = ld_gnt;
  assign mem_wdata = ld_data;
  assign mem_addr  = ld_gnt ? ld_addr : (pc_q[ADDR_W-1:0] + ADDR_W'(byte_idx_q));

  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_plus4    = instr_pc_q + 32'd4;

  // Big-endian insert: byte 0 lands in bits [31:24].
  assign ins_shift = {byte_idx_q, 3'b000};
  assign ins_mask  = 32'hFF00_0000 >> ins_shift;
  assign ins_byte  = {mem_rdata, 24'h00_0000} >> ins_shift;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    case (state_q)
      FETCH: begin
        if (ld_gnt) begin
          byte_idx_d = 2'd0;
        end else if (!redir_valid) begin
          instr_d = (instr_q & ~ins_mask) | ins_byte;
          if (byte_idx_q == LAST_IDX) begin
            state_d    = HOLD;
            byte_idx_d = 2'd0;
            instr_pc_d = pc_q;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      HOLD: begin
        if (instr_ready) begin
          state_d    = FETCH;
          byte_idx_d = 2'd0;
          pc_d       = pc_q + 32'd4;
        end
      end
      default: state_d = FETCH;
    endcase

    // Redirect overrides any sequential PC advance, including a same-cycle handshake.
    if (redir_valid) begin
      state_d    = FETCH;
      byte_idx_d = 2'd0;
      pc_d       = {redir_pc[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      byte_idx_q <= 2'd0;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// tb_fetch_sequencer : directed self-checking bench for fetch_sequencer
// Rev 1.0            : initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  localparam int AW = 7;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  logic          ld_gnt;
  logic          redir_valid;
  logic [31:0]   redir_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic [31:0]   pc_plus4;

  logic [7:0] mem [0:(1<<AW)-1];

  int n_pass;
  int n_total;

  fetch_sequencer #(.ADDR_W(AW), .RESET_PC(32'd0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_gnt      (ld_gnt),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .pc_plus4    (pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    mem[0]   = 8'h20; mem[1]   = 8'h08; mem[2]   = 8'h00; mem[3]   = 8'h05;
    mem[4]   = 8'h21; mem[5]   = 8'h29; mem[6]   = 8'h00; mem[7]   = 8'h01;
    mem[40]  = 8'hAA; mem[41]  = 8'hBB; mem[42]  = 8'hCC; mem[43]  = 8'hDD;
    mem[124] = 8'h11; mem[125] = 8'h22; mem[126] = 8'h33; mem[127] = 8'h44;

    rst_n       = 1'b0;
    ld_req      = 1'b1;
    ld_addr     = 7'd9;
    ld_data     = 8'h5A;
    redir_valid = 1'b0;
    redir_pc    = 32'd0;
    instr_ready = 1'b1;

    // Reset values, loader locked out while reset is held
    step(2);
    check("rst_valid",  {31'd0, instr_valid}, 32'd0);
    check("rst_instr",  instr,                32'd0);
    check("rst_pc",     instr_pc,             32'd0);
    check("rst_gnt",    {31'd0, ld_gnt},      32'd0);
    check("rst_we",     {31'd0, mem_we},      32'd0);
    ld_req = 1'b0;
    rst_n  = 1'b1;

    // First instruction: valid on the 4th edge after release
    step(3);
    check("i0_notyet", {31'd0, instr_valid}, 32'd0);
    check("i0_addr3",  {25'd0, mem_addr},    32'd3);
    step(1);
    check("i0_valid",  {31'd0, instr_valid}, 32'd1);
    check("i0_instr",  instr,                32'h2008_0005);
    check("i0_pc",     instr_pc,             32'd0);
    check("i0_pc4",    pc_plus4,             32'd4);

    // Second instruction five cycles later
    step(1);
    check("i1_drop",   {31'd0, instr_valid}, 32'd0);
    check("i1_addr",   {25'd0, mem_addr},    32'd4);
    step(3);
    check("i1_notyet", {31'd0, instr_valid}, 32'd0);
    step(1);
    check("i1_valid",  {31'd0, instr_valid}, 32'd1);
    check("i1_instr",  instr,                32'h2129_0001);
    check("i1_pc",     instr_pc,             32'd4);
    check("i1_pc4",    pc_plus4,             32'd8);

    // Back-pressure: hold for 3 cycles
    instr_ready = 1'b0;
    step(3);
    check("bp_valid", {31'd0, instr_valid}, 32'd1);
    check("bp_instr", instr,                32'h2129_0001);
    check("bp_pc",    instr_pc,             32'd4);
    check("bp_addr",  {25'd0, mem_addr},    32'd4);
    instr_ready = 1'b1;
    step(1);
    check("bp_acc",   {31'd0, instr_valid}, 32'd0);
    check("bp_next",  {25'd0, mem_addr},    32'd8);

    // Redirect at byte_idx 2 discards the partial word; target is word-aligned
    step(2);
    check("rd_idx2", {25'd0, mem_addr}, 32'd10);
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_002B;
    step(1);
    redir_valid = 1'b0;
    check("rd_addr",  {25'd0, mem_addr},    32'd40);
    check("rd_novld", {31'd0, instr_valid}, 32'd0);
    step(4);
    check("rd_valid", {31'd0, instr_valid}, 32'd1);
    check("rd_instr", instr,                32'hAABB_CCDD);
    check("rd_pc",    instr_pc,             32'h0000_0028);

    // Redirect coinciding with a handshake: target wins over pc+4
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_0004;
    step(1);
    redir_valid = 1'b0;
    check("rh_drop", {31'd0, instr_valid}, 32'd0);
    check("rh_addr", {25'd0, mem_addr},    32'd4);
    step(4);
    check("rh_instr", instr,    32'h2129_0001);
    check("rh_pc",    instr_pc, 32'd4);

    // Address wrap: target beyond the memory maps to bytes 124..127
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_00FD;
    step(1);
    redir_valid = 1'b0;
    check("wr_addr", {25'd0, mem_addr}, 32'd124);
    step(4);
    check("wr_instr", instr,    32'h1122_3344);
    check("wr_pc",    instr_pc, 32'h0000_00FC);
    check("wr_pc4",   pc_plus4, 32'h0000_0100);

    // Loader steals two cycles at byte_idx 2, fetch restarts from byte 0
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_0000;
    step(1);
    redir_valid = 1'b0;
    step(2);
    ld_req  = 1'b1;
    ld_addr = 7'd1;
    ld_data = 8'hFF;
    #1;
    check("ld_gnt1",  {31'd0, ld_gnt},   32'd1);
    check("ld_we1",   {31'd0, mem_we},   32'd1);
    check("ld_addr1", {25'd0, mem_addr}, 32'd1);
    check("ld_data1", {24'd0, mem_wdata}, 32'h0000_00FF);
    step(1);
    check("ld_gnt2",  {31'd0, ld_gnt},   32'd1);
    step(1);
    ld_req = 1'b0;
    #1;
    check("ld_rel",   {31'd0, ld_gnt},   32'd0);
    check("ld_relwe", {31'd0, mem_we},   32'd0);
    check("ld_refet", {25'd0, mem_addr}, 32'd0);
    step(3);
    check("ld_notyet", {31'd0, instr_valid}, 32'd0);
    step(1);
    check("ld_valid", {31'd0, instr_valid}, 32'd1);
    check("ld_instr", instr,                32'h20FF_0005);
    check("ld_pc",    instr_pc,             32'd0);

    // Asynchronous reset mid-fetch with the loader requesting
    step(2);
    ld_req  = 1'b1;
    ld_addr = 7'd2;
    ld_data = 8'h77;
    rst_n   = 1'b0;
    #1;
    check("ar_gnt",   {31'd0, ld_gnt},      32'd0);
    check("ar_we",    {31'd0, mem_we},      32'd0);
    check("ar_valid", {31'd0, instr_valid}, 32'd0);
    check("ar_instr", instr,                32'd0);
    check("ar_pc",    instr_pc,             32'd0);
    check("ar_addr",  {25'd0, mem_addr},    32'd0);
    ld_req = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(4);
    check("ar_rvalid", {31'd0, instr_valid}, 32'd1);
    check("ar_rinstr", instr,                32'h20FF_0005);
    check("ar_rpc",    instr_pc,             32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
